// File: rtl/uart_rx_byte_if.sv
// Serial receive bundle: the raw line in, and the byte and status strobes out.
// Ports: rx_in (serial line), dato (byte), rx_flat / frame_err (1-cycle strobes), rx_busy.
// The slave modport is the receiver side; the master modport is the line driver / byte consumer.
interface uart_rx_byte_if;
  logic       rx_in;
  logic [7:0] dato;
  logic       rx_flat;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx_in,
    input  dato,
    input  rx_flat,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  rx_in,
    output dato,
    output rx_flat,
    output frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver (8E1 with UART_RX_PARITY_EN defined): delivers each good byte on dato with a 1-cycle rx_flat.
// Latency: rx_flat rises SYNC_STAGES + 9.5*CLKS_PER_BIT (+-1) cycles after the start-bit falling edge.
// Backpressure: none; the consumer must take a byte on every rx_flat. Bad frames pulse frame_err and are dropped.
// Ports: clk, rst (async, active-high), rx (slave modport: rx_in, dato, rx_flat, frame_err, rx_busy).
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_byte_if.slave rx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Synchroniser resets to all ones so the line reads idle out of reset.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx.rx_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift_q;
  logic [7:0]    dato_q;
  logic          flat_q;
  logic          err_q;
  logic          busy_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift_q <= '0;
      dato_q  <= '0;
      flat_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      flat_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state  <= S_START;
            busy_q <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches; all later
        // samples land at mid-bit because counting restarts from here.
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= S_DATA;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt          <= '0;
            shift_q[idx] <= rx_s;
            idx          <= idx + 1'b1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: data bits plus parity bit must XOR to zero.
        S_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= ^{shift_q, rx_s};
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        // Leaving at mid stop bit gives half a bit of slack to catch a
        // start bit that follows immediately.
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              err_q <= 1'b1;
              state <= S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              err_q  <= 1'b1;
              state  <= S_IDLE;
              busy_q <= 1'b0;
`endif
            end else begin
              dato_q <= shift_q;
              flat_q <= 1'b1;
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A held-low line (break) must not be read as a stream of frames.
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.dato      = dato_q;
  assign rx.rx_flat   = flat_q;
  assign rx.frame_err = err_q;
  assign rx.rx_busy   = busy_q;

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART receive front end that feeds the 4-byte word packer. It oversamples the serial line, deserialises 8N1 frames (LSB first) and delivers each good byte on dato with a one-cycle rx_flat strobe. The packer consumes these two outputs directly. Framing errors are flagged, and bad bytes are dropped.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range 8..65535
SYNC_STAGES, 2, number of metastability flops on rx_in; legal range 2..3

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
rx_in  input  1  raw serial line, idles high, asynchronous to clk
dato  output  8  last good received byte; held until the next good byte
rx_flat  output  1  one-cycle strobe: dato has just been updated
frame_err  output  1  one-cycle strobe: stop bit (or parity) was bad
rx_busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (async, active-high):
  - dato=8'h00, rx_flat=0, frame_err=0, rx_busy=0.
  - FSM goes to IDLE; bit counter and cycle counter go to 0.
  - Synchroniser flops reset to 1 (line idle).
- Reset asserted mid-frame aborts the frame: no strobe, no change to dato after release.
- All FSM decisions use the synchronised line rx_s only; raw rx_in is never used.
- Cycle counter width: $clog2(CLKS_PER_BIT). Bit index: 3 bits.
- FSM states:
  - IDLE: rx_busy=0. On rx_s==0, go to START, clear cycle counter, set rx_busy=1.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit).
    - If rx_s==0, go to DATA with counters cleared.
    - If rx_s==1 (glitch), return to IDLE silently.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit[idx], LSB first.
    - After idx 7 is sampled, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s==1: on that same edge, load dato from the shift register and pulse rx_flat; go to IDLE.
    - rx_s==0: pulse frame_err, leave dato unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: rx_busy=1. Stay until rx_s==1, then go to IDLE. This prevents a break condition from generating frames.
- Strobes:
  - rx_flat and frame_err are registered, last exactly 1 cycle, and never both high.
  - rx_flat is deasserted in every cycle other than the valid stop-sample edge. The packer counts one byte per high cycle.
- Latency: rx_flat rises (SYNC_STAGES + 9.5*CLKS_PER_BIT ±1) cycles after the rx_in falling edge of the start bit.
- Back-to-back frames:
  - The FSM reaches IDLE at mid stop bit, so a start bit immediately following the stop bit is detected.
  - Tolerated baud mismatch: ±2%.
- No backpressure: the downstream block must accept a byte on every rx_flat.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined:
  - Frame becomes 8E1; a PARITY state is inserted between DATA and STOP.
  - Parity is sampled one bit period after data bit 7.
  - If the XOR of the 8 data bits and the parity bit is not 0, the frame is marked bad. At STOP, frame_err pulses instead of rx_flat (even when the stop bit is good), and the FSM goes to IDLE.
- Undefined: 8N1 only; no PARITY state; ports are unchanged.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and SYNC_STAGES=2.
- Frame 0xA5 (8N1) -> dato=8'hA5; rx_flat high for exactly 1 cycle at 2+152±1 cycles after the start edge; frame_err stays 0.
- rx_in low for 5 cycles, then high -> FSM returns to IDLE from START; no rx_flat and no frame_err; dato unchanged.
- Frame 0x3C with stop bit=0 and the line held low 40 more cycles -> frame_err 1-cycle pulse; no rx_flat; dato unchanged; rx_busy stays 1 until the line goes high.
- Back-to-back frames 0x11, 0x22, 0x33, 0x44 with no idle gap -> exactly four rx_flat pulses with dato 11, 22, 33, 44 in order; the downstream packer forms word 32'h44332211.
- rst pulsed at data bit 4 of frame 0xFF, then frame 0x5A -> after reset all outputs are 0; only 0x5A is delivered, with one rx_flat.
- With UART_RX_PARITY_EN: 0x07 with parity=1 -> rx_flat, dato=8'h07; the same frame with parity=0 -> frame_err only.
